div_check_scheduler: RTL and testbench

Shares one serial mod-DIVISOR residue engine between NUM_REQ requesters. Each requester offers a parallel word over a valid/ready handshake. The block grants requesters round-robin, shifts the granted word MSB-first through the residue recurrence, and returns a divisibility result tagged with the requester ID. It sits in front of the bit-serial divisibility datapath and serves as its only sequencer.

---
 rtl/div_check_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_div_check_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_check_scheduler.sv
// -----------------------------------------------------------------------------
// div_check_scheduler
//
// Purpose:
//   Shares one bit-serial mod-DIVISOR residue engine between NUM_REQ
//   requesters. Requesters offer parallel words over valid/ready. The
//   scheduler grants them round-robin, shifts the granted word MSB-first
//   through the residue recurrence (2*r + b, one conditional subtract per bit),
//   and returns a divisibility result tagged with the requester index.
//
// Parameters:
//   NUM_REQ    number of requesters (2..16)
//   DATA_WIDTH word width in bits (>= 1)
//   DIVISOR    modulus (>= 2)
//
// Optional feature macro:
//   DIV_SCHED_REM_OUT_EN  when defined, adds the rsp_rem output carrying the
//                         final residue. When undefined, the port and its
//                         register are absent; everything else is identical.
//
// Ports:
//   clk        in   clock, rising edge
//   resetn     in   asynchronous active-low reset
//   req_valid  in   [NUM_REQ]             per-requester word offered
//   req_data   in   [NUM_REQ*DATA_WIDTH]  requester i word at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready  out  [NUM_REQ]             one-hot grant/accept strobe (IDLE only)
//   rsp_valid  out                        result available (RESP state)
//   rsp_ready  in                         consumer accepts result
//   rsp_id     out  [ID_W]                index of the served requester
//   rsp_div    out                        1 when word mod DIVISOR == 0
//   rsp_rem    out  [REM_W]               word mod DIVISOR (macro builds only)
//   busy       out                        high whenever not IDLE
// -----------------------------------------------------------------------------
module div_check_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DIVISOR    = 5,
  localparam int ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int REM_W     = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [ID_W-1:0]                  rsp_id,
  output logic                             rsp_div,
`ifdef DIV_SCHED_REM_OUT_EN
  output logic [REM_W-1:0]                 rsp_rem,
`endif
  output logic                             busy
);

  // Bit counter must hold DATA_WIDTH-1.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // Modulus at the width of the doubled residue (2*r+b < 2*DIVISOR fits here).
  localparam logic [REM_W:0] DIV_C = (REM_W+1)'(DIVISOR);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_RESP
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                  state_q,   state_d;
  logic [ID_W-1:0]         rr_ptr_q,  rr_ptr_d;
  logic [DATA_WIDTH-1:0]   shreg_q,   shreg_d;
  logic [REM_W-1:0]        residue_q, residue_d;
  logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
  logic [ID_W-1:0]         rsp_id_q,  rsp_id_d;
  logic                    rsp_div_q, rsp_div_d;
`ifdef DIV_SCHED_REM_OUT_EN
  logic [REM_W-1:0]        rsp_rem_q, rsp_rem_d;
`endif

  // ---------------------------------------------------------------------------
  // Unpack the flat request bus into one word per requester
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      req_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter: first valid index at or after rr_ptr, wrapping.
  // The candidate sum is one bit wider so rr_ptr+k never overflows before the
  // modulo-NUM_REQ wrap, which also covers non-power-of-two NUM_REQ.
  // ---------------------------------------------------------------------------
  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W:0]   cand_sum;
  logic [ID_W-1:0] cand_idx;

  always_comb begin
    // NOTE: every signal written in an always_comb gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    cand_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      end
      cand_idx = cand_sum[ID_W-1:0];
      if (!grant_found && req_valid[cand_idx]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Residue recurrence step: t = 2*r + b, then one conditional subtract.
  // ---------------------------------------------------------------------------
  logic [REM_W:0]   t_val;
  logic [REM_W-1:0] res_step;

  assign t_val    = {residue_q, shreg_q[DATA_WIDTH-1]};
  assign res_step = (t_val >= DIV_C) ? REM_W'(t_val - DIV_C) : t_val[REM_W-1:0];

  // ---------------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    shreg_d   = shreg_q;
    residue_d = residue_q;
    bit_cnt_d = bit_cnt_q;
    rsp_id_d  = rsp_id_q;
    rsp_div_d = rsp_div_q;
`ifdef DIV_SCHED_REM_OUT_EN
    rsp_rem_d = rsp_rem_q;
`endif
    req_ready = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          shreg_d   = req_word[grant_idx];
          residue_d = '0;
          bit_cnt_d = CNT_W'(DATA_WIDTH - 1);
          rsp_id_d  = grant_idx;
          rr_ptr_d  = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
          state_d   = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        residue_d = res_step;
        shreg_d   = shreg_q << 1;
        bit_cnt_d = bit_cnt_q - CNT_W'(1);
        // Last bit: the result registers take the post-step residue so they
        // are valid in the same cycle rsp_valid rises.
        if (bit_cnt_q == '0) begin
          rsp_div_d = (res_step == '0);
`ifdef DIV_SCHED_REM_OUT_EN
          rsp_rem_d = res_step;
`endif
          state_d   = ST_RESP;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      shreg_q   <= '0;
      residue_q <= '0;
      bit_cnt_q <= '0;
      rsp_id_q  <= '0;
      rsp_div_q <= 1'b0;
`ifdef DIV_SCHED_REM_OUT_EN
      rsp_rem_q <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      shreg_q   <= shreg_d;
      residue_q <= residue_d;
      bit_cnt_q <= bit_cnt_d;
      rsp_id_q  <= rsp_id_d;
      rsp_div_q <= rsp_div_d;
`ifdef DIV_SCHED_REM_OUT_EN
      rsp_rem_q <= rsp_rem_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign rsp_valid = (state_q == ST_RESP);
  assign busy      = (state_q != ST_IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_div   = rsp_div_q;
`ifdef DIV_SCHED_REM_OUT_EN
  assign rsp_rem   = rsp_rem_q;
`endif

endmodule

// File: tb/tb_div_check_scheduler.sv
// -----------------------------------------------------------------------------
// tb_div_check_scheduler
//
// Self-checking bench for div_check_scheduler (NUM_REQ=4, DATA_WIDTH=8,
// DIVISOR=5). A negedge monitor pushes the expected result of every accepted
// word onto a scoreboard queue and pops/compares it when the response
// handshake occurs. A vector table plus hand-written sequences cover latency,
// round-robin order, back-pressure, mid-operation reset and an exhaustive sweep.
// Inputs change #1 after the rising edge; outputs are sampled on the falling
// edge.
// -----------------------------------------------------------------------------
module tb_div_check_scheduler;

  localparam int NR = 4;
  localparam int DW = 8;
  localparam int DV = 5;

  logic            clk;
  logic            resetn;
  logic [NR-1:0]   req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic            rsp_div;
`ifdef DIV_SCHED_REM_OUT_EN
  logic [2:0]      rsp_rem;
`endif
  logic            busy;

  div_check_scheduler #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW),
    .DIVISOR    (DV)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_div   (rsp_div),
`ifdef DIV_SCHED_REM_OUT_EN
    .rsp_rem   (rsp_rem),
`endif
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard
  typedef struct {
    int id;
    int dv;
    int rm;
  } exp_t;

  exp_t sb_q[$];
  int   grant_log[$];
  int   grant_cyc[$];

  // Monitor: record grants and compare responses.
  always @(negedge clk) begin
    if (resetn) begin
      if ((req_valid & req_ready) != '0) begin
        check("req_ready_onehot", $countones(req_ready), 1);
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            int w;
            exp_t e;
            w    = int'(req_data[i*DW +: DW]);
            e.id = i;
            e.dv = ((w % DV) == 0) ? 1 : 0;
            e.rm = w % DV;
            sb_q.push_back(e);
            grant_log.push_back(i);
            grant_cyc.push_back(cyc);
          end
        end
      end
      if (rsp_valid && rsp_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_rsp", 1, 0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_rsp_id", int'(rsp_id), e.id);
          check("sb_rsp_div", int'(rsp_div), e.dv);
`ifdef DIV_SCHED_REM_OUT_EN
          check("sb_rsp_rem", int'(rsp_rem), e.rm);
`endif
        end
      end
    end
  end

  // Async reset pulse; checks outputs while reset is held.
  task automatic do_reset();
    resetn    = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    sb_q.delete();
    grant_log.delete();
    grant_cyc.delete();
    #1;
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_id", int'(rsp_id), 0);
    check("rst_rsp_div", int'(rsp_div), 0);
    check("rst_busy", int'(busy), 0);
`ifdef DIV_SCHED_REM_OUT_EN
    check("rst_rsp_rem", int'(rsp_rem), 0);
`endif
    repeat (2) @(negedge clk);
    #2 resetn = 1'b1;
  endtask

  // Offer one word on one requester, wait for the grant and the response.
  // Returns at the negedge where rsp_valid is first seen; lat counts falling
  // edges from the grant cycle (9 for DATA_WIDTH=8), -1 on grant timeout.
  task automatic send_word(input int req, input logic [DW-1:0] w,
                           output int id, output int dv, output int rm,
                           output int lat);
    bit got;
    id = -1; dv = -1; rm = -1; lat = -1;
    @(posedge clk); #1;
    req_data[req*DW +: DW] = w;
    req_valid[req]         = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 50 && !got; c++) begin
      @(negedge clk);
      if (req_ready[req]) got = 1'b1;
    end
    if (!got) begin
      check("grant_timeout", 0, 1);
      req_valid[req] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[req] = 1'b0;
    @(negedge clk);
    check("req_ready_one_cycle", int'(req_ready), 0);
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) begin
      check("rsp_timeout", 0, 1);
      return;
    end
    id = int'(rsp_id);
    dv = int'(rsp_div);
`ifdef DIV_SCHED_REM_OUT_EN
    rm = int'(rsp_rem);
`else
    rm = 0;
`endif
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((busy || req_valid != '0) && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", int'(busy), 0);
  endtask

  task automatic wait_grants(input int n);
    int c;
    c = 0;
    while (grant_log.size() < n && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("grant_count", grant_log.size(), n);
  endtask

  // Vector table
  typedef struct {
    int          req;
    logic [DW-1:0] word;
    int          dv;
    int          rm;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int id, dv, rm, lat;
    int exp_order[$];

    vecs[0] = '{req: 0, word: 8'd25,  dv: 1, rm: 0};
    vecs[1] = '{req: 2, word: 8'd27,  dv: 0, rm: 2};
    vecs[2] = '{req: 2, word: 8'd255, dv: 1, rm: 0};
    vecs[3] = '{req: 2, word: 8'd0,   dv: 1, rm: 0};
    vecs[4] = '{req: 1, word: 8'd40,  dv: 1, rm: 0};
    vecs[5] = '{req: 3, word: 8'd7,   dv: 0, rm: 2};
    vecs[6] = '{req: 0, word: 8'd254, dv: 0, rm: 4};
    vecs[7] = '{req: 1, word: 8'd1,   dv: 0, rm: 1};

    resetn    = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;
    #2;
    do_reset();

    // Table-driven single words with latency check.
    for (int v = 0; v < 8; v++) begin
      send_word(vecs[v].req, vecs[v].word, id, dv, rm, lat);
      check($sformatf("vec%0d_latency", v), lat, DW + 1);
      check($sformatf("vec%0d_id", v), id, vecs[v].req);
      check($sformatf("vec%0d_div", v), dv, vecs[v].dv);
`ifdef DIV_SCHED_REM_OUT_EN
      check($sformatf("vec%0d_rem", v), rm, vecs[v].rm);
`endif
    end
    wait_idle();

    // Round robin: all four valid, then only 1 and 3.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(10*i + 3);
    req_valid = 4'b1111;
    wait_grants(5);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    exp_order = '{0, 1, 2, 3, 0};
    for (int g = 0; g < 5 && g < grant_log.size(); g++) begin
      check($sformatf("rr4_order%0d", g), grant_log[g], exp_order[g]);
      if (g > 0) check($sformatf("rr4_gap%0d", g), grant_cyc[g] - grant_cyc[g-1], DW + 2);
    end

    grant_log.delete();
    grant_cyc.delete();
    @(posedge clk); #1;
    req_valid = 4'b1010;
    wait_grants(4);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    exp_order = '{1, 3, 1, 3};
    for (int g = 0; g < 4 && g < grant_log.size(); g++) begin
      check($sformatf("rr2_order%0d", g), grant_log[g], exp_order[g]);
      if (g > 0) check($sformatf("rr2_gap%0d", g), grant_cyc[g] - grant_cyc[g-1], DW + 2);
    end

    // Back-pressure: word 40 on req 1, rsp_ready low for 5 RESP cycles.
    rsp_ready = 1'b0;
    send_word(1, 8'd40, id, dv, rm, lat);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check($sformatf("stall%0d_rsp_valid", c), int'(rsp_valid), 1);
      check($sformatf("stall%0d_rsp_id", c), int'(rsp_id), 1);
      check($sformatf("stall%0d_rsp_div", c), int'(rsp_div), 1);
      check($sformatf("stall%0d_req_ready", c), int'(req_ready), 0);
      check($sformatf("stall%0d_busy", c), int'(busy), 1);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", int'(rsp_valid), 1);
    @(negedge clk);
    check("stall_done_valid", int'(rsp_valid), 0);
    check("stall_done_busy", int'(busy), 0);

    // Reset during the third SHIFT cycle drops the word.
    do_reset();
    @(posedge clk); #1;
    req_data[2*DW +: DW] = 8'd10;
    req_valid[2]         = 1'b1;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 20 && !got; c++) begin
        @(negedge clk);
        if (req_ready[2]) got = 1'b1;
      end
      check("midrst_grant", int'(got), 1);
    end
    @(posedge clk); #1;
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("midrst_busy_before", int'(busy), 1);
    resetn = 1'b0;
    sb_q.delete();
    #1;
    check("midrst_req_ready", int'(req_ready), 0);
    check("midrst_rsp_valid", int'(rsp_valid), 0);
    check("midrst_rsp_id", int'(rsp_id), 0);
    check("midrst_rsp_div", int'(rsp_div), 0);
    check("midrst_busy", int'(busy), 0);
    #2 resetn = 1'b1;
    @(posedge clk); #1;
    req_data[1*DW +: DW] = 8'd12;
    req_data[3*DW +: DW] = 8'd15;
    req_valid = 4'b1010;
    @(negedge clk);
    check("midrst_regrant", int'(req_ready), 2);
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle();
    check("midrst_sb_empty", sb_q.size(), 0);

    // Exhaustive sweep on requester 0.
    for (int v = 0; v < 256; v++) begin
      send_word(0, DW'(v), id, dv, rm, lat);
      check($sformatf("ex%0d_div", v), dv, ((v % DV) == 0) ? 1 : 0);
`ifdef DIV_SCHED_REM_OUT_EN
      check($sformatf("ex%0d_rem", v), rm, v % DV);
`endif
    end
    wait_idle();
    check("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
